env_writer: RTL and testbench
=============================

ENV_WRITER -- requirements
Module: env_writer

Interface
REQ-001 Parameter DECAY_STEP, default 1, signal decrement applied to every cell per sweep.
REQ-002 Clk  in  1  single system clock; all state on rising edge.
REQ-003 RESET_SIM_N  in  1  reset, asynchronous, active-low.
REQ-004 decay_start  in  1  one-cycle pulse requesting a full evaporation sweep.
REQ-005 dep_valid  in  1  ant deposit request valid.
REQ-006 dep_ready  out  1  deposit accepted when dep_valid and dep_ready are both high on a rising edge.
REQ-007 dep_X / dep_Y  in  X_bits / Y_bits  deposit cell coordinates.
REQ-008 dep_amount  in  SIGNAL_bits  pheromone amount to add.
REQ-009 dep_take_sugar  in  1  clear sugar bit of the target cell.
REQ-010 lookup_X / lookup_Y  out  X_bits / Y_bits  read address into the environment.
REQ-011 lookup_data  in  SIGNAL_bits+1  {signal, sugar}, sugar in bit 0, valid exactly one cycle after the address.
REQ-012 write_X  out  X_bits  write column.
REQ-013 write_flag_row  out  PIXELS_Y  one-hot row write enable, all-zero when not writing.
REQ-014 write_signal / write_sugar  out  SIGNAL_bits / 1  data to write.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 sweep_done  out  1  one-cycle pulse after the last cell of a sweep is written.
REQ-017 sweep_overrun  out  1  sticky; set when decay_start arrives while a sweep is already pending or active.

Function
REQ-018 FSM states: IDLE, SW_RD, SW_WR, DP_RD, DP_WR; every read-modify-write (RMW) is one RD cycle (address driven) followed by one WR cycle (data consumed, write asserted).
REQ-019 decay_start sets sweep_pending; the sweep covers cells in raster order, X fastest, (0,0) to (PIXELS_X-1, PIXELS_Y-1).
REQ-020 SW_WR writes signal = max(signal - DECAY_STEP, 0) and preserves sugar.
REQ-021 DP_WR writes signal = min(signal + dep_amount, 2^SIGNAL_bits - 1); sugar = 0 if dep_take_sugar, else preserved.
REQ-022 dep_ready is high only in IDLE and SW_WR; dep_X/Y/amount/take_sugar are captured on the handshake.
REQ-023 Handshake in IDLE or SW_WR -> next state DP_RD; after DP_WR -> SW_RD if the sweep is pending/active, else IDLE.
REQ-024 Deposit has priority over sweep at cell boundaries; the sweep resumes at the next unvisited cell, with none skipped or repeated.
REQ-025 Simultaneous decay_start and dep_valid in IDLE: deposit first, then the sweep starts at (0,0).
REQ-026 A deposit to a cell already swept in this pass is not decayed again; RMWs never overlap, so there is no read-after-write hazard.
REQ-027 Sweep-only latency: 2*PIXELS_X*PIXELS_Y cycles from the first SW_RD to sweep_done.
REQ-028 Coordinates at or beyond PIXELS_X/PIXELS_Y are accepted and the write is suppressed (write_flag_row all-zero).

Reset
REQ-029 Asserting RESET_SIM_N low forces IDLE, clears counters, sweep_pending, captured deposit and sweep_overrun, and drives write_flag_row=0, busy=0, sweep_done=0 and dep_ready=0 while low.
REQ-030 Reset mid-RMW aborts without a write; after release, dep_ready=1 (IDLE) on the first cycle.

Structure
REQ-031 The params.sv package holds PIXELS_X, PIXELS_Y, X_bits, Y_bits, SIGNAL_bits, SIGNAL_MAX and an env_cell_t {signal, sugar} typedef.
REQ-032 Saturating arithmetic lives in one combinational sub-module, env_cell_update (cell, mode, amount, take_sugar -> new cell).

Verification (bench uses an 8x8 grid, SIGNAL_bits=4, DECAY_STEP=1)
REQ-033 All cells signal=3 -> pulse decay_start -> every cell reads 2, sweep_done 128 cycles after the first SW_RD.
REQ-034 Cell (2,5)=13 -> deposit amount 7 -> cell=15 (saturated), sugar unchanged.
REQ-035 Cell (4,4)={0,1} -> sweep -> stays 0; deposit with take_sugar=1 -> sugar bit 0.
REQ-036 Deposits held valid during a sweep -> each accepted at an SW_WR; every cell is decayed exactly once; sweep_done is delayed 2 cycles per deposit.
REQ-037 decay_start while busy sweeping -> sweep_overrun=1 and stays set; no second sweep is started.
REQ-038 RESET_SIM_N low during DP_RD -> no write_flag_row pulse; all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/env_writer_pkg.sv
// Shared grid geometry, cell format and state encoding for the environment writer.
package env_writer_pkg;

    localparam int PIXELS_X    = 8;
    localparam int PIXELS_Y    = 8;
    localparam int X_bits      = 4;
    localparam int Y_bits      = 4;
    localparam int SIGNAL_bits = 4;

    localparam logic [SIGNAL_bits-1:0] SIGNAL_MAX = {SIGNAL_bits{1'b1}};
    localparam logic [X_bits-1:0]      X_LAST     = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0]      Y_LAST     = Y_bits'(PIXELS_Y - 1);

    // Sugar sits in bit 0, pheromone signal above it.
    typedef struct packed {
        logic [SIGNAL_bits-1:0] signal;
        logic                   sugar;
    } env_cell_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SW_RD = 3'd1,
        SW_WR = 3'd2,
        DP_RD = 3'd3,
        DP_WR = 3'd4
    } state_e;

    typedef enum logic {
        MODE_DECAY   = 1'b0,
        MODE_DEPOSIT = 1'b1
    } cell_mode_e;

    // True when the coordinate addresses a real cell of the grid.
    function automatic logic coord_in_range(input logic [X_bits-1:0] x,
                                            input logic [Y_bits-1:0] y);
        return ({1'b0, x} < (X_bits+1)'(PIXELS_X)) &&
               ({1'b0, y} < (Y_bits+1)'(PIXELS_Y));
    endfunction

endpackage

// File: rtl/env_cell_update.sv
// Saturating update of one environment cell: evaporation or pheromone deposit.
module env_cell_update
    import env_writer_pkg::*;
#(
    parameter int unsigned DECAY_STEP = 1
)
(
    input  env_cell_t              cell_i,
    input  cell_mode_e             mode_i,
    input  logic [SIGNAL_bits-1:0] amount_i,
    input  logic                   take_sugar_i,
    output env_cell_t              cell_o
);

    localparam logic [SIGNAL_bits:0] STEP_EXT = (SIGNAL_bits+1)'(DECAY_STEP);
    localparam logic [SIGNAL_bits:0] MAX_EXT  = {1'b0, SIGNAL_MAX};

    logic [SIGNAL_bits:0] sig_ext_s;
    logic [SIGNAL_bits:0] diff_s;
    logic [SIGNAL_bits:0] sum_s;

    // Decay floors at zero, deposit clips at SIGNAL_MAX; one extra bit catches the wrap.
    always_comb begin
        sig_ext_s = {1'b0, cell_i.signal};
        diff_s    = sig_ext_s - STEP_EXT;
        sum_s     = sig_ext_s + {1'b0, amount_i};
        cell_o    = cell_i;
        case (mode_i)
            MODE_DECAY: begin
                if (sig_ext_s >= STEP_EXT) begin
                    cell_o.signal = diff_s[SIGNAL_bits-1:0];
                end else begin
                    cell_o.signal = {SIGNAL_bits{1'b0}};
                end
            end
            MODE_DEPOSIT: begin
                if (sum_s > MAX_EXT) begin
                    cell_o.signal = SIGNAL_MAX;
                end else begin
                    cell_o.signal = sum_s[SIGNAL_bits-1:0];
                end
                if (take_sugar_i) begin
                    cell_o.sugar = 1'b0;
                end else begin
                    cell_o.sugar = cell_i.sugar;
                end
            end
            default: begin
                cell_o = cell_i;
            end
        endcase
    end

endmodule

// File: rtl/env_writer.sv
// Environment writer: raster evaporation sweep interleaved with ant deposits,
// every cell access a two-cycle read-modify-write against an external grid.
module env_writer
    import env_writer_pkg::*;
#(
    parameter int unsigned DECAY_STEP = 1
)
(
    input  logic                   Clk,
    input  logic                   RESET_SIM_N,
    input  logic                   decay_start,
    input  logic                   dep_valid,
    output logic                   dep_ready,
    input  logic [X_bits-1:0]      dep_X,
    input  logic [Y_bits-1:0]      dep_Y,
    input  logic [SIGNAL_bits-1:0] dep_amount,
    input  logic                   dep_take_sugar,
    output logic [X_bits-1:0]      lookup_X,
    output logic [Y_bits-1:0]      lookup_Y,
    input  logic [SIGNAL_bits:0]   lookup_data,
    output logic [X_bits-1:0]      write_X,
    output logic [PIXELS_Y-1:0]    write_flag_row,
    output logic [SIGNAL_bits-1:0] write_signal,
    output logic                   write_sugar,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   sweep_overrun
);

    state_e                 state_q, state_d;
    logic [X_bits-1:0]      sw_x_q, sw_x_d;
    logic [Y_bits-1:0]      sw_y_q, sw_y_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic [X_bits-1:0]      dx_q, dx_d;
    logic [Y_bits-1:0]      dy_q, dy_d;
    logic [SIGNAL_bits-1:0] damt_q, damt_d;
    logic                   dtake_q, dtake_d;

    logic                   accept_s;
    logic                   last_cell_s;
    logic                   wr_en_s;
    logic [Y_bits-1:0]      wr_row_s;
    cell_mode_e             mode_s;
    env_cell_t              rd_cell_s;
    env_cell_t              new_cell_s;

    assign rd_cell_s = lookup_data;

    env_cell_update #(
        .DECAY_STEP (DECAY_STEP)
    ) u_cell_update (
        .cell_i       (rd_cell_s),
        .mode_i       (mode_s),
        .amount_i     (damt_q),
        .take_sugar_i (dtake_q),
        .cell_o       (new_cell_s)
    );

    // Address/write decode from the current state; ready is held low while in reset.
    always_comb begin
        dep_ready = RESET_SIM_N && ((state_q == IDLE) || (state_q == SW_WR));
        lookup_X  = sw_x_q;
        lookup_Y  = sw_y_q;
        write_X   = sw_x_q;
        wr_row_s  = sw_y_q;
        wr_en_s   = 1'b0;
        mode_s    = MODE_DECAY;
        case (state_q)
            SW_WR: begin
                wr_en_s = 1'b1;
            end
            DP_RD: begin
                lookup_X = dx_q;
                lookup_Y = dy_q;
            end
            DP_WR: begin
                write_X  = dx_q;
                wr_row_s = dy_q;
                wr_en_s  = 1'b1;
                mode_s   = MODE_DEPOSIT;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
        for (int r = 0; r < PIXELS_Y; r++) begin
            if (wr_en_s && coord_in_range(write_X, wr_row_s) && (wr_row_s == Y_bits'(r))) begin
                write_flag_row[r] = 1'b1;
            end else begin
                write_flag_row[r] = 1'b0;
            end
        end
        write_signal  = new_cell_s.signal;
        write_sugar   = new_cell_s.sugar;
        busy          = (state_q != IDLE);
        sweep_done    = done_q;
        sweep_overrun = overrun_q;
    end

    // Next-state: deposit capture, sweep bookkeeping and RMW sequencing.
    always_comb begin
        state_d     = state_q;
        sw_x_d      = sw_x_q;
        sw_y_d      = sw_y_q;
        active_d    = active_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        damt_d      = damt_q;
        dtake_d     = dtake_q;
        accept_s    = dep_valid && dep_ready;
        last_cell_s = (sw_x_q == X_LAST) && (sw_y_q == Y_LAST);

        if (accept_s) begin
            dx_d    = dep_X;
            dy_d    = dep_Y;
            damt_d  = dep_amount;
            dtake_d = dep_take_sugar;
        end else begin
            dtake_d = dtake_q;
        end

        if (decay_start) begin
            if (active_q) begin
                overrun_d = 1'b1;
            end else begin
                active_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = DP_RD;
                end else if (active_d) begin
                    state_d = SW_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            SW_RD: begin
                state_d = SW_WR;
            end
            SW_WR: begin
                if (last_cell_s) begin
                    sw_x_d   = {X_bits{1'b0}};
                    sw_y_d   = {Y_bits{1'b0}};
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else if (sw_x_q == X_LAST) begin
                    sw_x_d = {X_bits{1'b0}};
                    sw_y_d = sw_y_q + Y_bits'(1);
                end else begin
                    sw_x_d = sw_x_q + X_bits'(1);
                end
                if (accept_s) begin
                    state_d = DP_RD;
                end else if (!last_cell_s) begin
                    state_d = SW_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            DP_RD: begin
                state_d = DP_WR;
            end
            DP_WR: begin
                if (active_d) begin
                    state_d = SW_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            state_q   <= IDLE;
            sw_x_q    <= {X_bits{1'b0}};
            sw_y_q    <= {Y_bits{1'b0}};
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            dx_q      <= {X_bits{1'b0}};
            dy_q      <= {Y_bits{1'b0}};
            damt_q    <= {SIGNAL_bits{1'b0}};
            dtake_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_x_q    <= sw_x_d;
            sw_y_q    <= sw_y_d;
            active_q  <= active_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            damt_q    <= damt_d;
            dtake_q   <= dtake_d;
        end
    end

endmodule

// File: tb/tb_env_writer.sv
// Self-checking bench for env_writer: a grid memory model answers lookups and
// absorbs writes; expected grid contents come from a cell-level reference model.
module tb_env_writer;
    import env_writer_pkg::*;

    localparam int DSTEP = 1;
    localparam int SMAX  = 15;

    logic                   Clk = 1'b0;
    logic                   RESET_SIM_N = 1'b0;
    logic                   decay_start = 1'b0;
    logic                   dep_valid = 1'b0;
    logic                   dep_ready;
    logic [X_bits-1:0]      dep_X = '0;
    logic [Y_bits-1:0]      dep_Y = '0;
    logic [SIGNAL_bits-1:0] dep_amount = '0;
    logic                   dep_take_sugar = 1'b0;
    logic [X_bits-1:0]      lookup_X;
    logic [Y_bits-1:0]      lookup_Y;
    logic [SIGNAL_bits:0]   lookup_data;
    logic [X_bits-1:0]      write_X;
    logic [PIXELS_Y-1:0]    write_flag_row;
    logic [SIGNAL_bits-1:0] write_signal;
    logic                   write_sugar;
    logic                   busy;
    logic                   sweep_done;
    logic                   sweep_overrun;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    env_writer #(.DECAY_STEP(DSTEP)) dut (
        .Clk(Clk), .RESET_SIM_N(RESET_SIM_N), .decay_start(decay_start),
        .dep_valid(dep_valid), .dep_ready(dep_ready), .dep_X(dep_X), .dep_Y(dep_Y),
        .dep_amount(dep_amount), .dep_take_sugar(dep_take_sugar),
        .lookup_X(lookup_X), .lookup_Y(lookup_Y), .lookup_data(lookup_data),
        .write_X(write_X), .write_flag_row(write_flag_row),
        .write_signal(write_signal), .write_sugar(write_sugar),
        .busy(busy), .sweep_done(sweep_done), .sweep_overrun(sweep_overrun)
    );

    // Grid memory seen by the DUT, plus reference expectations.
    logic [SIGNAL_bits-1:0] env_sig  [PIXELS_X][PIXELS_Y];
    logic                   env_sug  [PIXELS_X][PIXELS_Y];
    logic [SIGNAL_bits-1:0] load_sig [PIXELS_X][PIXELS_Y];
    logic                   load_sug [PIXELS_X][PIXELS_Y];
    logic                   load_req = 1'b0;
    int                     exp_sig  [PIXELS_X][PIXELS_Y];
    bit                     exp_sug  [PIXELS_X][PIXELS_Y];
    int                     write_cnt = 0;
    int                     bad_flag_cnt = 0;

    // Grid memory: preload, row-enabled writes, one-cycle registered reads.
    always @(posedge Clk) begin
        if (load_req) begin
            for (int x = 0; x < PIXELS_X; x++) begin
                for (int y = 0; y < PIXELS_Y; y++) begin
                    env_sig[x][y] <= load_sig[x][y];
                    env_sug[x][y] <= load_sug[x][y];
                end
            end
        end else begin
            for (int y = 0; y < PIXELS_Y; y++) begin
                if (write_flag_row[y] && (write_X < X_bits'(PIXELS_X))) begin
                    env_sig[write_X[2:0]][y] <= write_signal;
                    env_sug[write_X[2:0]][y] <= write_sugar;
                end
            end
        end
        write_cnt <= write_cnt + $countones(write_flag_row);
        if ($countones(write_flag_row) > 1) bad_flag_cnt <= bad_flag_cnt + 1;
        if ((lookup_X < X_bits'(PIXELS_X)) && (lookup_Y < Y_bits'(PIXELS_Y)))
            lookup_data <= {env_sig[lookup_X[2:0]][lookup_Y[2:0]], env_sug[lookup_X[2:0]][lookup_Y[2:0]]};
        else
            lookup_data <= '0;
    end

    function automatic int dec_sig(input int s);
        return (s >= DSTEP) ? s - DSTEP : 0;
    endfunction

    function automatic int add_sig(input int s, input int a);
        return (s + a > SMAX) ? SMAX : s + a;
    endfunction

    function automatic int env_mismatches();
        int n = 0;
        for (int x = 0; x < PIXELS_X; x++)
            for (int y = 0; y < PIXELS_Y; y++)
                if (int'(env_sig[x][y]) != exp_sig[x][y] || env_sug[x][y] != exp_sug[x][y]) n++;
        return n;
    endfunction

    task automatic model_sweep();
        for (int x = 0; x < PIXELS_X; x++)
            for (int y = 0; y < PIXELS_Y; y++)
                exp_sig[x][y] = dec_sig(exp_sig[x][y]);
    endtask

    task automatic randomize_exp(input int lo, input int hi);
        for (int x = 0; x < PIXELS_X; x++)
            for (int y = 0; y < PIXELS_Y; y++) begin
                exp_sig[x][y] = $urandom_range(hi, lo);
                exp_sug[x][y] = 1'($urandom_range(1, 0));
            end
    endtask

    task automatic load_env();
        for (int x = 0; x < PIXELS_X; x++)
            for (int y = 0; y < PIXELS_Y; y++) begin
                load_sig[x][y] = SIGNAL_bits'(exp_sig[x][y]);
                load_sug[x][y] = exp_sug[x][y];
            end
        @(negedge Clk);
        load_req = 1'b1;
        @(posedge Clk);
        #1 load_req = 1'b0;
    endtask

    // Pulse decay_start (optionally with a deposit) and count edges until sweep_done.
    task automatic start_sweep(input bit with_dep, input int x, input int y, input int amt,
                               input bit take, output bit rdy, output int lat);
        @(negedge Clk);
        decay_start = 1'b1;
        dep_valid = with_dep;
        dep_X = X_bits'(x); dep_Y = Y_bits'(y);
        dep_amount = SIGNAL_bits'(amt); dep_take_sugar = take;
        rdy = dep_ready;
        @(posedge Clk);
        #1 decay_start = 1'b0;
        dep_valid = 1'b0;
        lat = 0;
        while (!sweep_done && lat < 400) begin
            @(posedge Clk);
            #1 lat++;
        end
    endtask

    task automatic do_deposit(input int x, input int y, input int amt, input bit take,
                              output bit rdy);
        @(negedge Clk);
        dep_valid = 1'b1;
        dep_X = X_bits'(x); dep_Y = Y_bits'(y);
        dep_amount = SIGNAL_bits'(amt); dep_take_sugar = take;
        rdy = dep_ready;
        @(posedge Clk);
        #1 dep_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if (busy !== 1'b0 || sweep_done !== 1'b0 || dep_ready !== 1'b0 ||
            write_flag_row !== '0 || sweep_overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b ready=%b flags=%b ovr=%b, all required 0",
                     busy, sweep_done, dep_ready, write_flag_row, sweep_overrun);
        end
        @(negedge Clk);
        RESET_SIM_N = 1'b1;
        #1;
        tests++;
        if (dep_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", dep_ready, busy);
        end
    endtask

    task automatic test_sweep_basic();
        int lat, w0; bit rdy;
        for (int x = 0; x < PIXELS_X; x++)
            for (int y = 0; y < PIXELS_Y; y++) begin
                exp_sig[x][y] = 3;
                exp_sug[x][y] = 1'($urandom_range(1, 0));
            end
        load_env();
        w0 = write_cnt;
        start_sweep(1'b0, 0, 0, 0, 1'b0, rdy, lat);
        model_sweep();
        @(posedge Clk); #1;
        tests++;
        if (lat !== 2 * PIXELS_X * PIXELS_Y) begin
            fails++;
            $display("FAIL sweep_latency: got %0d required %0d", lat, 2 * PIXELS_X * PIXELS_Y);
        end
        tests++;
        if (env_mismatches() !== 0) begin
            fails++;
            $display("FAIL sweep_cells: %0d cells wrong, required 0 (cell0 sig=%0d exp=%0d)",
                     env_mismatches(), env_sig[0][0], exp_sig[0][0]);
        end
        tests++;
        if (write_cnt - w0 !== PIXELS_X * PIXELS_Y) begin
            fails++;
            $display("FAIL sweep_writes: got %0d required %0d", write_cnt - w0, PIXELS_X * PIXELS_Y);
        end
        tests++;
        if (sweep_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep_end: done=%b busy=%b required 0 0", sweep_done, busy);
        end
    endtask

    task automatic test_deposit_saturate();
        bit rdy;
        randomize_exp(0, SMAX);
        exp_sig[2][5] = 13; exp_sug[2][5] = 1'b1;
        load_env();
        do_deposit(2, 5, 7, 1'b0, rdy);
        exp_sig[2][5] = add_sig(13, 7);
        tests++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL dep_ready_idle: got %b required 1", rdy);
        end
        tests++;
        if (env_sig[2][5] !== 4'd15 || env_sug[2][5] !== 1'b1) begin
            fails++;
            $display("FAIL dep_saturate: got sig=%0d sugar=%b required sig=15 sugar=1",
                     env_sig[2][5], env_sug[2][5]);
        end
        tests++;
        if (env_mismatches() !== 0) begin
            fails++;
            $display("FAIL dep_others: %0d cells wrong, required 0", env_mismatches());
        end
    endtask

    task automatic test_sugar();
        bit rdy; int lat; int amt;
        randomize_exp(0, SMAX);
        exp_sig[4][4] = 0; exp_sug[4][4] = 1'b1;
        load_env();
        start_sweep(1'b0, 0, 0, 0, 1'b0, rdy, lat);
        model_sweep();
        @(posedge Clk); #1;
        tests++;
        if (env_sig[4][4] !== 4'd0 || env_sug[4][4] !== 1'b1) begin
            fails++;
            $display("FAIL decay_floor: got sig=%0d sugar=%b required sig=0 sugar=1",
                     env_sig[4][4], env_sug[4][4]);
        end
        amt = $urandom_range(SMAX, 0);
        do_deposit(4, 4, amt, 1'b1, rdy);
        exp_sig[4][4] = add_sig(0, amt); exp_sug[4][4] = 1'b0;
        tests++;
        if (int'(env_sig[4][4]) !== exp_sig[4][4] || env_sug[4][4] !== 1'b0) begin
            fails++;
            $display("FAIL take_sugar: got sig=%0d sugar=%b required sig=%0d sugar=0",
                     env_sig[4][4], env_sug[4][4], exp_sig[4][4]);
        end
        tests++;
        if (env_mismatches() !== 0) begin
            fails++;
            $display("FAIL sugar_grid: %0d cells wrong, required 0", env_mismatches());
        end
    endtask

    // Deposits held valid during a sweep; cell values chosen so decay/deposit order cannot matter.
    task automatic test_deposits_during_sweep();
        int nd, delay, di, cyc, lat, w0, acc_busy, cx, cy;
        int dx[$], dy[$], da[$]; bit dt[$];
        bit used [PIXELS_X][PIXELS_Y];
        bit rdy, done_seen;
        randomize_exp(1, 8);
        load_env();
        for (int x = 0; x < PIXELS_X; x++)
            for (int y = 0; y < PIXELS_Y; y++) used[x][y] = 1'b0;
        nd = $urandom_range(6, 3);
        while (dx.size() < nd) begin
            cx = $urandom_range(PIXELS_X - 1, 0);
            cy = $urandom_range(PIXELS_Y - 1, 0);
            if (!used[cx][cy]) begin
                used[cx][cy] = 1'b1;
                dx.push_back(cx); dy.push_back(cy);
                da.push_back($urandom_range(7, 0)); dt.push_back(1'($urandom_range(1, 0)));
            end
        end
        delay = $urandom_range(40, 2);
        w0 = write_cnt; di = 0; cyc = 0; lat = -1; acc_busy = 0; done_seen = 1'b0;
        @(negedge Clk);
        decay_start = 1'b1;
        @(posedge Clk);
        #1 decay_start = 1'b0;
        while (!done_seen && cyc < 600) begin
            @(negedge Clk);
            if (cyc >= delay && di < nd) begin
                dep_valid = 1'b1;
                dep_X = X_bits'(dx[di]); dep_Y = Y_bits'(dy[di]);
                dep_amount = SIGNAL_bits'(da[di]); dep_take_sugar = dt[di];
            end else begin
                dep_valid = 1'b0;
            end
            rdy = dep_ready;
            if (dep_valid && rdy && busy) acc_busy++;
            @(posedge Clk);
            if (dep_valid && rdy) di++;
            #1 cyc++;
            if (sweep_done) begin done_seen = 1'b1; lat = cyc; end
        end
        dep_valid = 1'b0;
        model_sweep();
        for (int i = 0; i < nd; i++) begin
            exp_sig[dx[i]][dy[i]] = add_sig(exp_sig[dx[i]][dy[i]], da[i]);
            if (dt[i]) exp_sug[dx[i]][dy[i]] = 1'b0;
        end
        @(posedge Clk); #1;
        tests++;
        if (di !== nd || acc_busy !== nd) begin
            fails++;
            $display("FAIL mid_sweep_accept: accepted %0d (%0d while busy) required %0d", di, acc_busy, nd);
        end
        tests++;
        if (lat !== 2 * PIXELS_X * PIXELS_Y + 2 * nd) begin
            fails++;
            $display("FAIL mid_sweep_latency: got %0d required %0d", lat, 2 * PIXELS_X * PIXELS_Y + 2 * nd);
        end
        tests++;
        if (env_mismatches() !== 0 || write_cnt - w0 !== PIXELS_X * PIXELS_Y + nd) begin
            fails++;
            $display("FAIL mid_sweep_cells: %0d cells wrong, writes %0d required 0 and %0d",
                     env_mismatches(), write_cnt - w0, PIXELS_X * PIXELS_Y + nd);
        end
    endtask

    task automatic test_simultaneous();
        bit rdy; int lat;
        randomize_exp(0, SMAX);
        exp_sig[0][0] = 13; exp_sug[0][0] = 1'b1;
        load_env();
        start_sweep(1'b1, 0, 0, 7, 1'b0, rdy, lat);
        exp_sig[0][0] = add_sig(exp_sig[0][0], 7);
        model_sweep();
        @(posedge Clk); #1;
        tests++;
        if (rdy !== 1'b1 || lat !== 2 * PIXELS_X * PIXELS_Y + 2) begin
            fails++;
            $display("FAIL simult_timing: ready=%b latency=%0d required 1 and %0d",
                     rdy, lat, 2 * PIXELS_X * PIXELS_Y + 2);
        end
        tests++;
        if (env_sig[0][0] !== 4'd14 || env_mismatches() !== 0) begin
            fails++;
            $display("FAIL simult_order: cell0=%0d required 14, %0d cells wrong",
                     env_sig[0][0], env_mismatches());
        end
    endtask

    task automatic test_overrun();
        int lat, w0, busy_cnt;
        tests++;
        if (sweep_overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_initial: got %b required 0", sweep_overrun);
        end
        randomize_exp(0, SMAX);
        load_env();
        w0 = write_cnt;
        @(negedge Clk);
        decay_start = 1'b1;
        @(posedge Clk);
        #1 decay_start = 1'b0;
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        decay_start = 1'b1;
        @(posedge Clk);
        #1 decay_start = 1'b0;
        tests++;
        if (sweep_overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %b required 1", sweep_overrun);
        end
        lat = 21;
        while (!sweep_done && lat < 400) begin
            @(posedge Clk);
            #1 lat++;
        end
        tests++;
        if (lat !== 2 * PIXELS_X * PIXELS_Y) begin
            fails++;
            $display("FAIL overrun_latency: got %0d required %0d", lat, 2 * PIXELS_X * PIXELS_Y);
        end
        busy_cnt = 0;
        repeat (20) begin
            @(posedge Clk);
            #1 if (busy) busy_cnt++;
        end
        model_sweep();
        tests++;
        if (busy_cnt !== 0 || sweep_overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_no_restart: busy cycles %0d overrun=%b required 0 and 1",
                     busy_cnt, sweep_overrun);
        end
        tests++;
        if (env_mismatches() !== 0 || write_cnt - w0 !== PIXELS_X * PIXELS_Y) begin
            fails++;
            $display("FAIL overrun_cells: %0d cells wrong, writes %0d required 0 and %0d",
                     env_mismatches(), write_cnt - w0, PIXELS_X * PIXELS_Y);
        end
    endtask

    task automatic test_out_of_range();
        bit r1, r2; int w0;
        w0 = write_cnt;
        do_deposit(9, 2, 5, 1'b1, r1);
        do_deposit(3, 12, 5, 1'b1, r2);
        tests++;
        if (r1 !== 1'b1 || r2 !== 1'b1 || write_cnt - w0 !== 0 || env_mismatches() !== 0) begin
            fails++;
            $display("FAIL out_of_range: ready=%b%b writes=%0d bad cells=%0d required 11 0 0",
                     r1, r2, write_cnt - w0, env_mismatches());
        end
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        w0 = write_cnt;
        @(negedge Clk);
        dep_valid = 1'b1;
        dep_X = X_bits'(1); dep_Y = Y_bits'(1);
        dep_amount = SIGNAL_bits'(5); dep_take_sugar = 1'b1;
        @(posedge Clk);
        #1 dep_valid = 1'b0;
        #1 RESET_SIM_N = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || dep_ready !== 1'b0 || write_flag_row !== '0 ||
            sweep_done !== 1'b0 || sweep_overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_rmw: busy=%b ready=%b flags=%b done=%b ovr=%b required all 0",
                     busy, dep_ready, write_flag_row, sweep_done, sweep_overrun);
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        RESET_SIM_N = 1'b1;
        #1;
        tests++;
        if (dep_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_release: ready=%b required 1", dep_ready);
        end
        repeat (4) @(posedge Clk);
        #1;
        tests++;
        if (write_cnt - w0 !== 0 || env_mismatches() !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nowrite: writes=%0d bad cells=%0d busy=%b required 0 0 0",
                     write_cnt - w0, env_mismatches(), busy);
        end
        tests++;
        if (bad_flag_cnt !== 0) begin
            fails++;
            $display("FAIL row_onehot: %0d multi-row writes required 0", bad_flag_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_basic();
        test_deposit_saturate();
        test_sugar();
        test_deposits_during_sweep();
        test_simultaneous();
        test_overrun();
        test_out_of_range();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
